prime_det_arb: RTL
==================

# prime_det_arb

Round-robin arbiter and sequencer that shares one `prime_det` 3-bit primality detector among `N_REQ` requesters. Each requester presents a 3-bit operand with a level request. The block grants one requester at a time, drives the granted operand into the shared detector, registers the result, and returns it with a one-cycle acknowledge. It sits between the requesting datapaths and the single combinational `prime_det` instance.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesters, legal range 2..8.
- `CNT_W`, default 8: width of each per-requester statistics counter.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `req`, input, `N_REQ`: level request, one bit per requester.
- `data`, input, `3*N_REQ`: operands; requester i occupies bits `[3i+2:3i]`.
- `ack`, output, `N_REQ`: one-hot, one-cycle result-valid pulse.
- `is_prime`, output, 1: result, valid only while `ack` is nonzero.
- `busy`, output, 1: high whenever the FSM is not in IDLE.
- `stats_clr`, input, 1: synchronous clear of all statistics counters.
- `hit_cnt`, output, `CNT_W*N_REQ`: per-requester prime-hit counts.

## Operation
- FSM has three states: IDLE, EVAL, RESP.
- **IDLE:**
  - Apply the mask: `eff_req = req & ~mask`.
  - If `eff_req` is nonzero, select the winner by round-robin search starting at `ptr` and ascending modulo `N_REQ`.
  - Latch the winner index into `gnt_idx` and its operand into `opnd`, then go to EVAL.
  - Otherwise stay in IDLE.
- **EVAL:** `opnd` drives `prime_det`; register the detector output into `res`; go to RESP.
- **RESP:**
  - `ack[gnt_idx]` = 1 and `is_prime` = `res`.
  - Set `ptr = (gnt_idx+1) mod N_REQ`.
  - Set `mask` = one-hot of `gnt_idx` for exactly the next IDLE cycle; it clears afterwards.
  - Go to IDLE.
- Primality over 0..7: 2, 3, 5 and 7 give 1; 0, 1, 4 and 6 give 0.
- Requester contract:
  - Hold `req` and `data` stable from assertion until its `ack` cycle.
  - Deassert `req` in the cycle after `ack`, or keep it asserted to request again.
  - A held `req` is re-served no earlier than the second IDLE after its `ack`.
- `data` is sampled only in the IDLE grant cycle; later changes do not affect the result.
- A `req` that drops before being granted is simply not served; no error is raised.

## Timing
- Reset values: `ack` = 0, `is_prime` = 0, `busy` = 0, `ptr` = 0, `mask` = 0, `hit_cnt` = 0, state = IDLE.
- Latency: `req` sampled high in IDLE at edge T gives `ack` high during cycle T+2, for one cycle.
- Throughput: one transaction per 3 cycles; no back-to-back acks.
- `busy` is high in EVAL and RESP.
- Fairness: with all requesters asserting continuously, grants rotate 0,1,...,N_REQ-1,0,...
- Simultaneous requests are resolved only by `ptr`; there is no fixed priority.
- Reset mid-transaction:
  - Return immediately to IDLE with `ack` = 0.
  - The in-flight result is discarded and no ack is issued.
  - Requesters must re-request.
- `stats_clr` coinciding with a RESP prime hit: the clear wins and the counter ends at 0.

## Configuration
- Macro `PRIME_ARB_STATS_EN`.
- **Defined:**
  - In RESP with `res` = 1, `hit_cnt[gnt_idx]` increments.
  - Counters saturate at `2^CNT_W-1`.
  - `stats_clr` zeroes all counters.
- **Undefined:**
  - `hit_cnt` is tied to 0.
  - `stats_clr` is ignored.
  - No counter flops are built.
  - The port list is unchanged.

## Structure
- Shared package `prime_pkg` holds:
  - `PRIME_W = 3`.
  - The state enum `{IDLE, EVAL, RESP}`.
  - The `CNT_W` default constant.
- The only sub-module is the existing `prime_det` (ports A, B, C, F).
  - Instantiate it once, with A = `opnd[2]`, B = `opnd[1]`, C = `opnd[0]`.
- Implement round-robin selection as a function in the arbiter, not as a separate module.

## Test plan
- Reset and single requester: `req[0]`=1 with `data0`=5 gives `ack[0]` exactly 2 cycles after grant, `is_prime`=1; `data0`=4 gives `is_prime`=0.
- Exhaustive operand sweep on requester 2 over values 0..7 gives `is_prime` sequence 0,0,1,1,0,1,0,1.
- All four `req` held high with operands 2, 4, 7, 6 gives acks in order 0,1,2,3,0 with results 1,0,1,0,1, and 3-cycle spacing.
- Mask check: `req[1]` held alone gives successive `ack[1]` pulses no closer than 4 cycles apart.
- `rst_n` asserted during EVAL gives no ack, all outputs return to reset values, and the next grant starts from `ptr` = 0.
- With `PRIME_ARB_STATS_EN`, `CNT_W`=2, and 5 prime hits on requester 3, `hit_cnt[3]` saturates at 3; pulsing `stats_clr` returns it to 0.

Source files
------------

// File: rtl/prime_pkg.sv
// Shared definitions for the prime detector arbiter: operand width,
// sequencer states and the default statistics counter width.
package prime_pkg;

    localparam int PRIME_W   = 3;
    localparam int CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/prime_det.sv
// Combinational 3-bit primality detector: F = 1 for operands 2, 3, 5, 7.
// A is the operand MSB, C the LSB.
module prime_det (
    input  logic A,
    input  logic B,
    input  logic C,
    output logic F
);

    // 2,3 share the pattern 01x; 5,7 share 1x1.
    assign F = (~A & B) | (A & C);

endmodule

// File: rtl/prime_det_arb.sv
// Round-robin arbiter/sequencer sharing one prime_det among N_REQ requesters.
// Each transaction walks IDLE (grant) -> EVAL (detect) -> RESP (respond).
// The ack/is_prime outputs are registered, so they are visible in the cycle
// after RESP, which is also the one IDLE cycle in which the just-served
// requester is masked out.
// Optional per-requester prime-hit counters are built when the macro
// PRIME_ARB_STATS_EN is defined; otherwise hit_cnt is tied to zero.
module prime_det_arb
    import prime_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req,
    input  logic [PRIME_W*N_REQ-1:0] data,
    output logic [N_REQ-1:0]         ack,
    output logic                     is_prime,
    output logic                     busy,
    input  logic                     stats_clr,
    output logic [CNT_W*N_REQ-1:0]   hit_cnt
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   gnt_q, gnt_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [N_REQ-1:0]   mask_q, mask_d;
    logic [PRIME_W-1:0] opnd_q, opnd_d;
    logic               res_q, res_d;
    logic [N_REQ-1:0]   ack_q, ack_d;
    logic               is_prime_q, is_prime_d;

    logic [N_REQ-1:0]   eff_req;
    logic [IDX_W-1:0]   pick;
    logic               det_f;

    // First set bit of r at or after position p, wrapping modulo N_REQ.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                                 input logic [IDX_W-1:0] p);
        logic [IDX_W-1:0] w;
        logic             found;
        int               idx;
        w     = '0;
        found = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(p) + k) % N_REQ;
            if (!found && r[idx]) begin
                w     = IDX_W'(idx);
                found = 1'b1;
            end
        end
        return w;
    endfunction

    prime_det u_det (
        .A (opnd_q[2]),
        .B (opnd_q[1]),
        .C (opnd_q[0]),
        .F (det_f)
    );

    assign eff_req = req & ~mask_q;
    assign pick    = rr_pick(eff_req, ptr_q);

    // Next-state and output decode for the grant/evaluate/respond sequence.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        ptr_d      = ptr_q;
        mask_d     = '0;
        opnd_d     = opnd_q;
        res_d      = res_q;
        ack_d      = '0;
        is_prime_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (|eff_req) begin
                    gnt_d   = pick;
                    opnd_d  = data[PRIME_W*int'(pick) +: PRIME_W];
                    state_d = EVAL;
                end
            end
            EVAL: begin
                res_d   = det_f;
                state_d = RESP;
            end
            RESP: begin
                ack_d[gnt_q]  = 1'b1;
                is_prime_d    = res_q;
                mask_d[gnt_q] = 1'b1;
                ptr_d         = (int'(gnt_q) == N_REQ - 1) ? '0 : gnt_q + IDX_W'(1);
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Sequencer state and registered outputs; reset drops any in-flight result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            ptr_q      <= '0;
            mask_q     <= '0;
            opnd_q     <= '0;
            res_q      <= 1'b0;
            ack_q      <= '0;
            is_prime_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            ptr_q      <= ptr_d;
            mask_q     <= mask_d;
            opnd_q     <= opnd_d;
            res_q      <= res_d;
            ack_q      <= ack_d;
            is_prime_q <= is_prime_d;
        end
    end

    assign ack      = ack_q;
    assign is_prime = is_prime_q;
    assign busy     = (state_q != IDLE);

`ifdef PRIME_ARB_STATS_EN
    logic [N_REQ-1:0][CNT_W-1:0] cnt_q, cnt_d;

    // Saturating prime-hit counters; a clear overrides a same-cycle hit.
    always_comb begin
        cnt_d = cnt_q;
        if (stats_clr) begin
            cnt_d = '0;
        end else if (state_q == RESP && res_q && cnt_q[gnt_q] != {CNT_W{1'b1}}) begin
            cnt_d[gnt_q] = cnt_q[gnt_q] + CNT_W'(1);
        end
    end

    // Counter storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign hit_cnt = cnt_q;
`else
    logic stats_clr_unused;
    assign stats_clr_unused = stats_clr;
    assign hit_cnt          = '0;
`endif

endmodule
